// File: rtl/instr_loader.sv
// Packs a big-endian UART byte stream into 32-bit words for the instruction RAM; stops after the 0xFFFFFFFF halt word.
// Latency: write one cycle after the 4th byte. No backpressure: bytes arriving during a write start the next word.
module instr_loader #(
   parameter int RAM_WIDTH      = 32,
   parameter int RAM_DEPTH      = 2048,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_start,
   input  logic [7:0]                 i_rx_data,
   input  logic                       i_rx_valid,
   output logic [RAM_WIDTH-1:0]       o_addra,
   output logic [RAM_WIDTH-1:0]       o_dina,
   output logic                       o_wea,
   output logic                       o_ena,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_error,
   output logic [$clog2(RAM_DEPTH):0] o_word_count
);

   localparam int AW = $clog2(RAM_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CW = $clog2(RAM_DEPTH) + 1;
   localparam logic [AW-1:0]        LAST_ADDR = AW'(RAM_DEPTH - 1);
   localparam logic [TW-1:0]        TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [RAM_WIDTH-1:0] HALT_WORD = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t               state_q, state_d;
   logic [RAM_WIDTH-1:0] sr_q, sr_d;
   logic [RAM_WIDTH-1:0] dina_q, dina_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [AW-1:0]        next_q, next_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [1:0]           bcnt_q, bcnt_d;
   logic [TW-1:0]        tmo_q, tmo_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         sr_q    <= '0;
         dina_q  <= '0;
         addr_q  <= '0;
         next_q  <= '0;
         cnt_q   <= '0;
         bcnt_q  <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         dina_q  <= dina_d;
         addr_q  <= addr_d;
         next_q  <= next_d;
         cnt_q   <= cnt_d;
         bcnt_q  <= bcnt_d;
         tmo_q   <= tmo_d;
      end
   end

   // addr_q/dina_q are the RAM-facing copies, so they only move when a word is committed.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      dina_d  = dina_q;
      addr_d  = addr_q;
      next_d  = next_q;
      cnt_d   = cnt_q;
      bcnt_d  = bcnt_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         S_RECV: begin
            if (i_rx_valid) begin
               sr_d  = {sr_q[RAM_WIDTH-9:0], i_rx_data};
               tmo_d = '0;
               if (bcnt_q == 2'd3) begin
                  bcnt_d  = 2'd0;
                  dina_d  = {sr_q[RAM_WIDTH-9:0], i_rx_data};
                  addr_d  = next_q;
                  cnt_d   = cnt_q + CW'(1);
                  state_d = S_WRITE;
               end else begin
                  bcnt_d = bcnt_q + 2'd1;
               end
            end else if (bcnt_q != 2'd0) begin
               if (tmo_q == TMO_LAST) begin
                  state_d = S_ERROR;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end
         end
         S_WRITE: begin
            tmo_d  = '0;
            bcnt_d = 2'd0;
            if (dina_q == HALT_WORD) begin
               state_d = S_DONE;
            end else if (addr_q == LAST_ADDR) begin
               state_d = S_ERROR;
            end else begin
               state_d = S_RECV;
               next_d  = next_q + AW'(1);
               // A byte landing in the write cycle opens the next word.
               if (i_rx_valid) begin
                  sr_d   = {sr_q[RAM_WIDTH-9:0], i_rx_data};
                  bcnt_d = 2'd1;
               end
            end
         end
         default: begin
            if (i_start) begin
               state_d = S_RECV;
               addr_d  = '0;
               next_d  = '0;
               cnt_d   = '0;
               bcnt_d  = 2'd0;
               tmo_d   = '0;
            end
         end
      endcase
   end

   assign o_wea        = (state_q == S_WRITE);
   assign o_ena        = (state_q == S_WRITE);
   assign o_busy       = (state_q == S_RECV) || (state_q == S_WRITE);
   assign o_done       = (state_q == S_DONE);
   assign o_error      = (state_q == S_ERROR);
   assign o_addra      = RAM_WIDTH'(addr_q);
   assign o_dina       = dina_q;
   assign o_word_count = cnt_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed scenarios with literal expectations plus randomized byte streams,
// all checked every cycle against a queue-based reference model.
module tb_instr_loader;

   localparam int DEPTH = 4;
   localparam int TMO   = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [31:0] o_addra, o_dina;
   logic        o_wea, o_ena, o_busy, o_done, o_error;
   logic [2:0]  o_word_count;

   instr_loader #(.RAM_WIDTH(32), .RAM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .o_addra(o_addra), .o_dina(o_dina), .o_wea(o_wea), .o_ena(o_ena), .o_busy(o_busy),
      .o_done(o_done), .o_error(o_error), .o_word_count(o_word_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: bytes collect in a queue; four of them make a word.
   logic [7:0]  mq[$];
   logic        m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, m_pend = 1'b0;
   logic [31:0] m_pw = '0;
   int          m_pa = 0, m_next = 0, m_cnt = 0, m_tmo = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         m_busy = 0; m_done = 0; m_err = 0; m_pend = 0;
         m_pw = '0; m_pa = 0; m_next = 0; m_cnt = 0; m_tmo = 0;
      end else if (m_pend) begin
         m_pend = 0;
         m_tmo  = 0;
         mq.delete();
         if (m_pw == 32'hFFFF_FFFF) begin
            m_busy = 0; m_done = 1;
         end else if (m_pa == DEPTH - 1) begin
            m_busy = 0; m_err = 1;
         end else begin
            m_next = m_pa + 1;
            if (rx_valid) mq.push_back(rx_data);
         end
      end else if (m_busy) begin
         if (rx_valid) begin
            mq.push_back(rx_data);
            m_tmo = 0;
            if (mq.size() == 4) begin
               m_pw = {mq[0], mq[1], mq[2], mq[3]};
               m_pa = m_next;
               m_cnt++;
               m_pend = 1;
               mq.delete();
            end
         end else if (mq.size() != 0) begin
            m_tmo++;
            if (m_tmo == TMO) begin
               m_busy = 0; m_err = 1;
               mq.delete();
            end
         end
      end else if (start) begin
         m_busy = 1; m_done = 0; m_err = 0;
         m_next = 0; m_cnt = 0; m_tmo = 0;
         mq.delete();
      end
   end

   typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
   wr_t wr_log[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_wea", {31'd0, o_wea}, 0);
         chk("rst_busy", {31'd0, o_busy}, 0);
         chk("rst_done", {31'd0, o_done}, 0);
         chk("rst_error", {31'd0, o_error}, 0);
         chk("rst_count", {29'd0, o_word_count}, 0);
         chk("rst_addra", o_addra, 0);
         chk("rst_dina", o_dina, 0);
      end else begin
         chk("wea", {31'd0, o_wea}, {31'd0, m_pend});
         chk("ena", {31'd0, o_ena}, {31'd0, m_pend});
         chk("busy", {31'd0, o_busy}, {31'd0, m_busy});
         chk("done", {31'd0, o_done}, {31'd0, m_done});
         chk("error", {31'd0, o_error}, {31'd0, m_err});
         chk("word_count", {29'd0, o_word_count}, m_cnt);
         if (m_pend) begin
            chk("addra", o_addra, m_pa);
            chk("dina", o_dina, m_pw);
         end
         if (o_wea) wr_log.push_back('{a: o_addra, d: o_dina});
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic chk_log(input string nm, input int idx, input logic [31:0] a, input logic [31:0] d);
      if (wr_log.size() > idx) begin
         chk({nm, "_addr"}, wr_log[idx].a, a);
         chk({nm, "_data"}, wr_log[idx].d, d);
      end else begin
         chk({nm, "_present"}, wr_log.size(), idx + 1);
      end
   endtask

   initial begin
      idle(2);
      chk("init_busy", {31'd0, o_busy}, 0);
      chk("init_count", {29'd0, o_word_count}, 0);
      rst_n = 1'b1;
      idle(1);

      // Two-word program ending in the halt word.
      wr_log.delete();
      pulse_start();
      send_word(32'h0000_0008);
      chk("t1_wea_latency", {31'd0, o_wea}, 1);
      send_word(32'hFFFF_FFFF);
      idle(3);
      chk("t1_nwrites", wr_log.size(), 2);
      chk_log("t1_w0", 0, 32'd0, 32'h0000_0008);
      chk_log("t1_w1", 1, 32'd1, 32'hFFFF_FFFF);
      chk("t1_done", {31'd0, o_done}, 1);
      chk("t1_count", {29'd0, o_word_count}, 2);

      // MSB-first assembly.
      wr_log.delete();
      pulse_start();
      chk("t2_done_cleared", {31'd0, o_done}, 0);
      send_word(32'h1234_5678);
      send_word(32'hFFFF_FFFF);
      idle(2);
      chk_log("t2_w0", 0, 32'd0, 32'h1234_5678);

      // Memory full without a halt word.
      wr_log.delete();
      pulse_start();
      for (int w = 0; w < 4; w++) send_word(32'h1020_3040 + w);
      idle(3);
      chk("t3_nwrites", wr_log.size(), 4);
      chk_log("t3_w3", 3, 32'd3, 32'h1020_3043);
      chk("t3_error", {31'd0, o_error}, 1);
      pulse_start();
      chk("t3_error_cleared", {31'd0, o_error}, 0);
      chk("t3_busy", {31'd0, o_busy}, 1);

      // Inter-byte timeout: 15 idle clocks survive, the 16th trips.
      wr_log.delete();
      send_byte(8'h5A);
      send_byte(8'hA5);
      idle(TMO - 1);
      chk("t4_no_early_timeout", {31'd0, o_error}, 0);
      idle(1);
      chk("t4_timeout", {31'd0, o_error}, 1);
      chk("t4_nwrites", wr_log.size(), 0);
      pulse_start();
      idle(1000);
      chk("t4_idle_no_error", {31'd0, o_error}, 0);
      chk("t4_idle_busy", {31'd0, o_busy}, 1);

      // Byte arriving in the write cycle.
      wr_log.delete();
      foreach (t5_bytes[i]) send_byte(t5_bytes[i]);
      idle(2);
      chk_log("t5_w0", 0, 32'd0, 32'hAABB_CCDD);
      chk_log("t5_w1", 1, 32'd1, 32'hEEFF_0011);

      // Reset in the middle of a word.
      send_byte(8'h22);
      rst_n = 1'b0;
      #1;
      chk("t6_wea", {31'd0, o_wea}, 0);
      chk("t6_busy", {31'd0, o_busy}, 0);
      chk("t6_count", {29'd0, o_word_count}, 0);
      chk("t6_addra", o_addra, 0);
      chk("t6_dina", o_dina, 0);
      wr_log.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      pulse_start();
      chk("t6_reload_count", {29'd0, o_word_count}, 0);
      chk("t6_reload_busy", {31'd0, o_busy}, 1);
      send_word(32'hFFFF_FFFF);
      idle(2);
      chk_log("t6_w0", 0, 32'd0, 32'hFFFF_FFFF);
      chk("t6_done", {31'd0, o_done}, 1);
      chk("t6_final_count", {29'd0, o_word_count}, 1);

      // Randomized streams: halts, gaps near the timeout, stray starts and resets.
      for (int w = 0; w < 400; w++) begin
         int r;
         bit halt;
         r = $urandom_range(0, 99);
         if (r < 2) begin
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
         end else if (r < 20) begin
            pulse_start();
         end
         halt = ($urandom_range(0, 5) == 0);
         for (int b = 0; b < 4; b++) begin
            int g;
            int gap;
            g = $urandom_range(0, 9);
            gap = (g < 6) ? 0 : (g < 9) ? $urandom_range(1, 3) : $urandom_range(12, 20);
            idle(gap);
            send_byte(halt ? 8'hFF : 8'($urandom));
         end
      end
      idle(30);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   logic [7:0] t5_bytes [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h11};

endmodule
